// File: rtl/chip_6502_bus_pkg.sv
// chip_6502_bus_pkg
//   Shared constants for the 6502 memory-side bus sequencer:
//   phase-FSM state encoding, bus widths and default timing parameters.
package chip_6502_bus_pkg;

  // Phase FSM encoding; the state value equals the phi level it drives.
  localparam logic ST_LO = 1'b0;
  localparam logic ST_HI = 1'b1;

  localparam int AW = 16;
  localparam int DW = 8;

  localparam int HALF_CYCLE_DEF   = 8;
  localparam int RESET_CYCLES_DEF = 8;

endpackage

// File: rtl/chip_6502_bus.sv
// chip_6502_bus
//   Memory-side bus sequencer for the gate-level 6502 core. Generates phi,
//   holds the core in reset for RESET_CYCLES phi cycles, and converts each
//   CPU cycle into one request/acknowledge transaction. phi is held high
//   (stretched) until the transaction of the current cycle has completed.
//
// Ports
//   clk, res        FPGA clock, asynchronous active-low reset
//   phi, cpu_res    6502 clock and active-low core reset
//   ab, rw, sync    core address, read(1)/write(0), opcode-fetch flag
//   dbo, dbi        core data out, registered data into the core
//   mem_*           simple memory port (req/we/addr/wdata/rdata/ack)
//   fetch           one-clk pulse, coincident with the ack of a sync read
//   dbg_state       current phase FSM state (ST_LO / ST_HI)
//
// Handshake: mem_req rises with mem_addr/mem_we/mem_wdata already stable and
// holds them until the clock after mem_ack. mem_ack is a one-clock pulse and
// is honoured only in a clock where the registered mem_req reads high
// (including the first such clock); an ack at any other time is ignored.
module chip_6502_bus
  import chip_6502_bus_pkg::*;
#(
  parameter int HALF_CYCLE   = HALF_CYCLE_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          res,
  output logic          phi,
  output logic          cpu_res,
  input  logic [AW-1:0] ab,
  input  logic          rw,
  input  logic          sync,
  input  logic [DW-1:0] dbo,
  output logic [DW-1:0] dbi,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          fetch,
  output logic          dbg_state
);

  localparam int CW = $clog2(HALF_CYCLE);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYCLE - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES);

  logic          state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rst_cnt;
  logic          sync_q;
  logic          done;
  logic          ack_ok;
  logic          cnt_last;

  assign ack_ok    = mem_req & mem_ack;
  assign cnt_last  = (cnt == CNT_LAST);
  // Combinational so the pulse lines up with the ack clock itself.
  assign fetch     = (state == ST_HI) & ack_ok & ~mem_we & sync_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= ST_LO;
      cnt       <= '0;
      rst_cnt   <= '0;
      phi       <= 1'b0;
      cpu_res   <= 1'b0;
      dbi       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      sync_q    <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_LO: begin
          if (cnt_last) begin
            // Address and direction have settled by the end of phi low.
            mem_addr <= ab;
            mem_we   <= ~rw;
            sync_q   <= sync;
            mem_req  <= rw;
            state    <= ST_HI;
            phi      <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (!cnt_last) begin
            cnt <= cnt + 1'b1;
          end
          if (ack_ok) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) begin
              dbi <= mem_rdata;
            end
          end
          // Write data from the core is only valid late in phi high.
          if (mem_we && cnt_last && !mem_req && !done) begin
            mem_wdata <= dbo;
            mem_req   <= 1'b1;
          end
          // Including ack_ok here means an ack at the last settle clock
          // ends the phase without an extra stretch clock.
          if (cnt_last && (done || ack_ok)) begin
            state <= ST_LO;
            phi   <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            if (rst_cnt != RST_LAST) begin
              rst_cnt <= rst_cnt + 1'b1;
              if (rst_cnt == RST_LAST - 1'b1) begin
                cpu_res <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip_6502_bus.sv
// tb_chip_6502_bus
//   Directed bench for chip_6502_bus with HALF_CYCLE=4, RESET_CYCLES=3.
module tb_chip_6502_bus;

  logic        clk;
  logic        res;
  logic        phi;
  logic        cpu_res;
  logic [15:0] ab;
  logic        rw;
  logic        sync;
  logic [7:0]  dbo;
  logic [7:0]  dbi;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        fetch;
  logic        dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  chip_6502_bus #(
    .HALF_CYCLE  (4),
    .RESET_CYCLES(3)
  ) dut (
    .clk      (clk),
    .res      (res),
    .phi      (phi),
    .cpu_res  (cpu_res),
    .ab       (ab),
    .rw       (rw),
    .sync     (sync),
    .dbo      (dbo),
    .dbi      (dbi),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .fetch    (fetch),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phi"},       {31'd0, phi},       32'd0);
    check({tag, "_cpu_res"},   {31'd0, cpu_res},   32'd0);
    check({tag, "_dbi"},       {24'd0, dbi},       32'd0);
    check({tag, "_mem_req"},   {31'd0, mem_req},   32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_fetch"},     {31'd0, fetch},     32'd0);
    check({tag, "_state"},     {31'd0, dbg_state}, 32'd0);
  endtask

  // Driver: runs from any point in phi-low until the next phi falling edge.
  // The memory acks on the ack_k-th clock (0-based) in which mem_req is high;
  // spur drives one ack in the first phi-high clock with mem_req low.
  task automatic bus_cycle(
    input  logic [15:0] a,
    input  logic        r,
    input  logic        s,
    input  logic [7:0]  wd,
    input  logic [7:0]  rd,
    input  int          ack_k,
    input  logic        spur,
    output int          hi_len,
    output int          nreq,
    output int          nfetch,
    output int          addr_bad,
    output logic        we_seen,
    output logic [7:0]  wdata_seen,
    output logic [7:0]  dbi_post,
    output logic        timeout
  );
    int   k         = 0;
    logic seen_hi   = 1'b0;
    logic prev_req  = 1'b0;
    logic acked     = 1'b0;
    logic post_done = 1'b0;
    logic spur_done = 1'b0;
    logic ended     = 1'b0;
    hi_len     = 0;
    nreq       = 0;
    nfetch     = 0;
    addr_bad   = 0;
    we_seen    = 1'bx;
    wdata_seen = 8'hxx;
    dbi_post   = 8'hxx;
    timeout    = 1'b1;
    ab         = a;
    rw         = r;
    sync       = s;
    dbo        = wd;
    mem_rdata  = rd;
    mem_ack    = 1'b0;
    for (int i = 0; i < 80 && !ended; i++) begin
      @(negedge clk);
      if (acked && !post_done) begin
        dbi_post  = dbi;
        post_done = 1'b1;
      end
      if (seen_hi && !phi) begin
        ended   = 1'b1;
        timeout = 1'b0;
      end
      if (phi) begin
        seen_hi = 1'b1;
        hi_len++;
      end
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!prev_req) nreq++;
        if (mem_addr !== a) addr_bad++;
        we_seen    = mem_we;
        wdata_seen = mem_wdata;
        if (k == ack_k) begin
          mem_ack = 1'b1;
          acked   = 1'b1;
        end
        k++;
      end else if (spur && phi && !spur_done) begin
        mem_ack   = 1'b1;
        spur_done = 1'b1;
      end
      prev_req = mem_req;
      #1;
      if (fetch) nfetch++;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int          hi_len, nreq, nfetch, addr_bad;
    logic        we_seen, timeout;
    logic [7:0]  wdata_seen, dbi_post;
    logic        prev_phi, prev_req, cpu_res_seen;
    int          nfall, nreq_pu, last_rise, period;
    logic        req_seen;

    res       = 1'b0;
    ab        = 16'h0000;
    rw        = 1'b1;
    sync      = 1'b0;
    dbo       = 8'h00;
    mem_rdata = 8'h00;
    mem_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_values("reset");

    // Power-up: reads acked in the same clock as they are seen
    res          = 1'b1;
    ab           = 16'hFFFC;
    rw           = 1'b1;
    mem_rdata    = 8'h11;
    prev_phi     = 1'b0;
    prev_req     = 1'b0;
    cpu_res_seen = 1'b0;
    nfall        = 0;
    nreq_pu      = 0;
    last_rise    = -1;
    period       = -1;
    for (int i = 0; i < 200 && !cpu_res_seen; i++) begin
      @(negedge clk);
      if (phi && !prev_phi) begin
        if (last_rise >= 0 && period < 0) period = i - last_rise;
        last_rise = i;
      end
      if (!phi && prev_phi) nfall++;
      if (mem_req && !prev_req) nreq_pu++;
      mem_ack = mem_req;
      if (cpu_res) cpu_res_seen = 1'b1;
      prev_phi = phi;
      prev_req = mem_req;
    end
    check("pu_cpu_res_rose", {31'd0, cpu_res_seen}, 32'd1);
    check("pu_phi_period", period, 32'd8);
    check("pu_fall_at_cpu_res", nfall, 32'd3);
    check("pu_reads_before_cpu_res", nreq_pu, 32'd3);
    check("pu_dbi", {24'd0, dbi}, 32'h11);
    mem_ack = 1'b0;

    // Opcode fetch read of A9 at F000
    bus_cycle(16'hF000, 1'b1, 1'b1, 8'h00, 8'hA9, 0, 1'b0,
              hi_len, nreq, nfetch, addr_bad, we_seen, wdata_seen, dbi_post, timeout);
    check("rd_timeout", {31'd0, timeout}, 32'd0);
    check("rd_hi_len", hi_len, 32'd4);
    check("rd_nreq", nreq, 32'd1);
    check("rd_addr", addr_bad, 32'd0);
    check("rd_we", {31'd0, we_seen}, 32'd0);
    check("rd_dbi", {24'd0, dbi_post}, 32'hA9);
    check("rd_fetch", nfetch, 32'd1);

    // Write 5C to 0080 with a spurious ack before the request
    bus_cycle(16'h0080, 1'b0, 1'b0, 8'h5C, 8'hEE, 0, 1'b1,
              hi_len, nreq, nfetch, addr_bad, we_seen, wdata_seen, dbi_post, timeout);
    check("wr_timeout", {31'd0, timeout}, 32'd0);
    check("wr_hi_len", hi_len, 32'd5);
    check("wr_nreq", nreq, 32'd1);
    check("wr_addr", addr_bad, 32'd0);
    check("wr_we", {31'd0, we_seen}, 32'd1);
    check("wr_wdata", {24'd0, wdata_seen}, 32'h5C);
    check("wr_dbi_hold", {24'd0, dbi_post}, 32'hA9);
    check("wr_fetch", nfetch, 32'd0);

    // Read stalled 10 clocks past counter saturation
    bus_cycle(16'h1234, 1'b1, 1'b0, 8'h00, 8'h3C, 13, 1'b0,
              hi_len, nreq, nfetch, addr_bad, we_seen, wdata_seen, dbi_post, timeout);
    check("stall_timeout", {31'd0, timeout}, 32'd0);
    check("stall_hi_len", hi_len, 32'd14);
    check("stall_nreq", nreq, 32'd1);
    check("stall_addr", addr_bad, 32'd0);
    check("stall_dbi", {24'd0, dbi_post}, 32'h3C);
    check("stall_fetch", nfetch, 32'd0);

    // Ack exactly on the last settle clock: no stretch
    bus_cycle(16'hF001, 1'b1, 1'b1, 8'h00, 8'h77, 3, 1'b0,
              hi_len, nreq, nfetch, addr_bad, we_seen, wdata_seen, dbi_post, timeout);
    check("edge_timeout", {31'd0, timeout}, 32'd0);
    check("edge_hi_len", hi_len, 32'd4);
    check("edge_dbi", {24'd0, dbi_post}, 32'h77);
    check("edge_fetch", nfetch, 32'd1);

    // Spurious ack in phi low after a sync read
    mem_rdata = 8'hEE;
    mem_ack   = 1'b1;
    #1;
    check("spur_fetch", {31'd0, fetch}, 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    check("spur_dbi", {24'd0, dbi}, 32'h77);
    check("spur_phi", {31'd0, phi}, 32'd0);

    // Reset asserted mid-HI with an unacknowledged read pending
    ab       = 16'h2000;
    rw       = 1'b1;
    sync     = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 40 && !req_seen; i++) begin
      @(negedge clk);
      if (mem_req) req_seen = 1'b1;
    end
    check("midres_req_seen", {31'd0, req_seen}, 32'd1);
    repeat (2) @(negedge clk);
    res = 1'b0;
    #1;
    check_reset_values("midres");
    @(negedge clk);
    res = 1'b1;

    // Clean restart after release
    bus_cycle(16'hC0DE, 1'b1, 1'b0, 8'h00, 8'h5A, 1, 1'b0,
              hi_len, nreq, nfetch, addr_bad, we_seen, wdata_seen, dbi_post, timeout);
    check("restart_timeout", {31'd0, timeout}, 32'd0);
    check("restart_hi_len", hi_len, 32'd4);
    check("restart_nreq", nreq, 32'd1);
    check("restart_addr", addr_bad, 32'd0);
    check("restart_dbi", {24'd0, dbi_post}, 32'h5A);
    check("restart_cpu_res", {31'd0, cpu_res}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/chip_6502_bus.md
# chip_6502_bus

Bus sequencer and responder on the memory side of the gate-level 6502 core. It generates the `phi` clock and holds the core's reset through power-up. It samples `ab`/`rw`/`dbo` at the correct phase points and turns each CPU cycle into a single request/acknowledge transaction on a simple memory port. Read data is driven onto the core's `dbi`, and `phi` is stretched while memory is slow. It sits between `chip_6502` and the Atari 2600 address decoder (ROM/RAM/TIA/RIOT).

## Interface
- `HALF_CYCLE`, 8: FPGA clocks per `phi` half-phase. This is the netlist settle time; minimum 2.
- `RESET_CYCLES`, 8: full `phi` cycles for which `cpu_res` stays low after `res` is released.
- `clk`  in  1  FPGA clock. This is the same clock that drives `chip_6502`.
- `res`  in  1  reset, asynchronous, active-low.
- `phi`  out  1  6502 clock to the core.
- `cpu_res`  out  1  core reset, active-low.
- `ab`  in  16  core address bus.
- `rw`  in  1  core read/write: 1 means read.
- `sync`  in  1  core opcode-fetch indicator.
- `dbo`  in  8  core data out.
- `dbi`  out  8  data into the core, registered.
- `mem_req`  out  1  transaction request.
- `mem_we`  out  1  1 means write.
- `mem_addr`  out  16  transaction address.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  single-cycle completion pulse.
- `fetch`  out  1  one-`clk` pulse when an opcode-fetch read completes.

## Operation
- **Reset values** (`res` low): `phi`=0, `cpu_res`=0, `dbi`=8'h00, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `fetch`=0, state LO, half-phase counter `cnt`=0, reset counter=0.
- **Assertion mid-transaction**: asserting `res` mid-transaction returns the block to the reset values immediately. The pending request is dropped, and memory must tolerate the abandoned `mem_req`.
- **State LO** (`phi`=0):
  - `cnt` counts 0..HALF_CYCLE-1.
  - On the clock where `cnt`=HALF_CYCLE-1, latch `mem_addr`←`ab`, `mem_we`←~`rw`, and the sync flag←`sync`.
  - On that same clock, a read raises `mem_req`; a write does not.
  - Then go to HI with `cnt`=0 and `phi`=1.
- **State HI** (`phi`=1):
  - `cnt` counts up and saturates at HALF_CYCLE-1.
  - Read: on `mem_ack`, set `dbi`←`mem_rdata`, drop `mem_req` on the next clock, and set the done flag. `fetch` pulses on the ack clock if the sync flag is set.
  - Write: on the clock where `cnt`=HALF_CYCLE-1, latch `mem_wdata`←`dbo` and raise `mem_req`. The done flag is set on `mem_ack`.
  - Leave HI (`phi`←0, `cnt`←0, clear done) only when `cnt`=HALF_CYCLE-1 and done is set. Until then `phi` stays high, which is the clock stretch.
- **Handshake**:
  - `mem_req` stays high until the clock after `mem_ack`.
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high.
  - `mem_ack` is honoured only while `mem_req` is high, including in the same clock that `mem_req` first reads high; otherwise it is ignored.
  - At most one transaction is issued per `phi` cycle.
- **`dbi` hold**: `dbi` holds its last read value through write cycles.
- **Core reset**:
  - While `cpu_res`=0 the sequencer runs normally: `phi` toggles and reads are performed.
  - The reset counter increments on each HI→LO transition.
  - `cpu_res` goes to 1 on the transition on which the counter reaches RESET_CYCLES, and the counter saturates there.

## Timing
- With no stall, one `phi` cycle is exactly 2×HALF_CYCLE clocks.
- Read request rises on the LO→HI edge. An ack arriving at or before HI `cnt`=HALF_CYCLE-1 gives no stretch.
- A stall extends HI by exactly (ack clock − clock at which `cnt` reached HALF_CYCLE-1) clocks.
- `dbi` is valid from the clock after ack until the next read ack.
- A write issues its request at HI `cnt`=HALF_CYCLE-1, so the minimum write stretch is 1 clock when ack arrives in the same clock.
- `fetch` is a single clock wide and coincident with `mem_ack`.

## Structure
- Shared package `chip_6502_bus_pkg` holds:
  - the state encoding (LO, HI);
  - the width constants AW=16 and DW=8;
  - the default values of HALF_CYCLE and RESET_CYCLES.
- Single flat module; no sub-module is needed.
- The settle counter, reset counter and phase FSM are all in one always block with the asynchronous reset.

## Test plan
- **Reset release, HALF_CYCLE=4, RESET_CYCLES=3, ack same clock**: `phi` period is 8 clocks; `cpu_res` rises on the 3rd falling edge of `phi`; three read requests are observed before it rises.
- **Read of 8'hA9 at `ab`=16'hF000, `sync`=1**: `mem_addr`=16'hF000 and `mem_we`=0; `dbi`=8'hA9 one clock after ack; `fetch` pulses once.
- **Write of `dbo`=8'h5C to 16'h0080**: `mem_we`=1 and `mem_wdata`=8'h5C during the request; `phi` high for HALF_CYCLE+1 clocks; `dbi` unchanged.
- **Read ack delayed 10 clocks after `cnt` saturates**: `phi` high for HALF_CYCLE+10 clocks; address is stable throughout the request; exactly one request.
- **Spurious `mem_ack` while `mem_req`=0**: no change to `dbi`, done or `fetch`.
- **`res` asserted mid-HI with a request pending**: all outputs return to reset values in the same clock; the sequence restarts cleanly after release.
